// File: rtl/rv32i_decode_exec_wb.sv
// Decode / execute / write-back datapath of the multicycle RV32I core.
// Also holds the byte-lane data memory used by loads and stores.
module rv32i_decode_exec_wb #(
    parameter int DMEM_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [31:0] INSTRUCTION,
    input  logic [31:0] PC,
    input  logic        DECODE_EN,
    input  logic        EXEC_EN,
    output logic [4:0]  RS1,
    output logic [4:0]  RS2,
    input  logic [31:0] RS1_VAL,
    input  logic [31:0] RS2_VAL,
    output logic [31:0] JUMP_DEST,
    output logic [31:0] EXEC_RD,
    output logic [31:0] MEMORY_OUT,
    output logic [4:0]  RD,
    output logic        WRITE_ENABLE,
    output logic [31:0] WRITE_DATA
);
    localparam int AW = $clog2(DMEM_WORDS);

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_OPIMM,
        CLS_OP
    } cls_t;

    cls_t        cls_d, cls_q;
    logic [31:0] imm_d, imm_q;
    logic [31:0] bpc_q;
    logic [2:0]  f3_q;
    logic        f7b5_q;
    logic [4:0]  rd_q;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign RS1 = INSTRUCTION[19:15];
    assign RS2 = INSTRUCTION[24:20];

    assign imm_i = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
    assign imm_s = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
    assign imm_b = {{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                    INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
    assign imm_u = {INSTRUCTION[31:12], 12'b0};
    assign imm_j = {{11{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                    INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};

    always_comb begin
        cls_d = CLS_NOP;
        imm_d = '0;
        case (INSTRUCTION[6:0])
            7'b0110111: begin cls_d = CLS_LUI;    imm_d = imm_u; end
            7'b0010111: begin cls_d = CLS_AUIPC;  imm_d = imm_u; end
            7'b1101111: begin cls_d = CLS_JAL;    imm_d = imm_j; end
            7'b1100111: begin cls_d = CLS_JALR;   imm_d = imm_i; end
            7'b1100011: begin cls_d = CLS_BRANCH; imm_d = imm_b; end
            7'b0000011: begin cls_d = CLS_LOAD;   imm_d = imm_i; end
            7'b0100011: begin cls_d = CLS_STORE;  imm_d = imm_s; end
            7'b0010011: begin cls_d = CLS_OPIMM;  imm_d = imm_i; end
            7'b0110011: begin cls_d = CLS_OP;     imm_d = imm_i; end
            default:    begin cls_d = CLS_NOP;    imm_d = '0;    end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            cls_q  <= CLS_NOP;
            imm_q  <= '0;
            bpc_q  <= '0;
            f3_q   <= '0;
            f7b5_q <= 1'b0;
            rd_q   <= '0;
        end else if (DECODE_EN) begin
            cls_q  <= cls_d;
            imm_q  <= imm_d;
            bpc_q  <= {PC[29:0], 2'b00};
            f3_q   <= INSTRUCTION[14:12];
            f7b5_q <= INSTRUCTION[30];
            rd_q   <= INSTRUCTION[11:7];
        end
    end

    // ---------------- execute ----------------
    logic [31:0] ea, op_b, alu, result, pc_rel;
    logic [4:0]  shamt;
    logic        taken;

    assign ea     = RS1_VAL + imm_q;
    assign pc_rel = bpc_q + imm_q;
    assign op_b   = (cls_q == CLS_OP) ? RS2_VAL : imm_q;
    assign shamt  = op_b[4:0];

    always_comb begin
        alu = '0;
        case (f3_q)
            3'd0:    alu = (cls_q == CLS_OP && f7b5_q) ? RS1_VAL - op_b : RS1_VAL + op_b;
            3'd1:    alu = RS1_VAL << shamt;
            3'd2:    alu = {31'b0, $signed(RS1_VAL) < $signed(op_b)};
            3'd3:    alu = {31'b0, RS1_VAL < op_b};
            3'd4:    alu = RS1_VAL ^ op_b;
            3'd5:    alu = f7b5_q ? 32'($signed(RS1_VAL) >>> shamt) : RS1_VAL >> shamt;
            3'd6:    alu = RS1_VAL | op_b;
            default: alu = RS1_VAL & op_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (f3_q)
            3'd0:    taken = RS1_VAL == RS2_VAL;
            3'd1:    taken = RS1_VAL != RS2_VAL;
            3'd4:    taken = $signed(RS1_VAL) < $signed(RS2_VAL);
            3'd5:    taken = $signed(RS1_VAL) >= $signed(RS2_VAL);
            3'd6:    taken = RS1_VAL < RS2_VAL;
            3'd7:    taken = RS1_VAL >= RS2_VAL;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        result = ea;
        case (cls_q)
            CLS_LUI:           result = imm_q;
            CLS_AUIPC:         result = pc_rel;
            CLS_JAL, CLS_JALR: result = bpc_q + 32'd4;
            CLS_OPIMM, CLS_OP: result = alu;
            default:           result = ea;
        endcase
    end

    // JALR's bit-0 clear disappears in the word shift, so ea[31:2] is exact.
    always_comb begin
        JUMP_DEST = PC + 32'd1;
        case (cls_q)
            CLS_JAL:    JUMP_DEST = {2'b00, pc_rel[31:2]};
            CLS_JALR:   JUMP_DEST = {2'b00, ea[31:2]};
            CLS_BRANCH: if (taken) JUMP_DEST = {2'b00, pc_rel[31:2]};
            default:    JUMP_DEST = PC + 32'd1;
        endcase
    end

    // ---------------- data memory ----------------
    logic [AW-1:0] word_idx;
    logic [3:0]    store_be;
    logic [31:0]   store_data;
    logic          mem_we, load_exec;
    logic [31:0]   ld_word;
    logic [31:0]   exec_rd_q;
    logic [2:0]    ld_f3_q;
    logic [1:0]    ld_off_q;

    assign word_idx  = ea[AW+1:2];
    assign mem_we    = EXEC_EN && !RSTN && (cls_q == CLS_STORE);
    assign load_exec = EXEC_EN && (cls_q == CLS_LOAD);

    always_comb begin
        store_be   = 4'b1111;
        store_data = RS2_VAL;
        case (f3_q[1:0])
            2'b00: begin
                store_be   = 4'b0001 << ea[1:0];
                store_data = {4{RS2_VAL[7:0]}};
            end
            2'b01: begin
                store_be   = ea[1] ? 4'b1100 : 4'b0011;
                store_data = {2{RS2_VAL[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = RS2_VAL;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DMEM_WORDS];
        logic [7:0] rd_byte_q;

        always_ff @(posedge CLK) begin
            if (mem_we && store_be[gi]) begin
                lane_mem[word_idx] <= store_data[8*gi +: 8];
            end
        end

        always_ff @(posedge CLK) begin
            if (RSTN) begin
                rd_byte_q <= '0;
            end else if (load_exec) begin
                rd_byte_q <= lane_mem[word_idx];
            end
        end

        assign ld_word[8*gi +: 8] = rd_byte_q;
    end

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            exec_rd_q <= '0;
            ld_f3_q   <= '0;
            ld_off_q  <= '0;
        end else if (EXEC_EN) begin
            exec_rd_q <= result;
            if (cls_q == CLS_LOAD) begin
                ld_f3_q  <= f3_q;
                ld_off_q <= ea[1:0];
            end
        end
    end

    // Lane/extension select is applied on the registered raw word.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = ld_word[7:0];
        case (ld_off_q)
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            2'd3:    ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = ld_off_q[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_f3_q)
            3'd0:    MEMORY_OUT = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    MEMORY_OUT = {{16{ld_half[15]}}, ld_half};
            3'd4:    MEMORY_OUT = {24'b0, ld_byte};
            3'd5:    MEMORY_OUT = {16'b0, ld_half};
            default: MEMORY_OUT = ld_word;
        endcase
    end

    // ---------------- write-back ----------------
    assign EXEC_RD = exec_rd_q;
    assign RD      = rd_q;

    always_comb begin
        WRITE_ENABLE = 1'b0;
        case (cls_q)
            CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
            CLS_LOAD, CLS_OPIMM, CLS_OP: WRITE_ENABLE = (rd_q != 5'd0);
            default:                     WRITE_ENABLE = 1'b0;
        endcase
    end

    assign WRITE_DATA = (cls_q == CLS_LOAD) ? MEMORY_OUT : exec_rd_q;

    logic unused_bits;
    assign unused_bits = ^{pc_rel[1:0], PC[31:30]};
endmodule

// File: tb/tb_rv32i_decode_exec_wb.sv
// Directed checks of decode/execute/write-back plus a small CPU shell that
// runs a recursive fib program on the block.
module tb_rv32i_decode_exec_wb;
    logic        CLK = 1'b0;
    logic        RSTN;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic        DECODE_EN;
    logic        EXEC_EN;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic [31:0] RS1_VAL;
    logic [31:0] RS2_VAL;
    logic [31:0] JUMP_DEST;
    logic [31:0] EXEC_RD;
    logic [31:0] MEMORY_OUT;
    logic [4:0]  RD;
    logic        WRITE_ENABLE;
    logic [31:0] WRITE_DATA;

    rv32i_decode_exec_wb #(.DMEM_WORDS(1024)) dut (
        .CLK(CLK), .RSTN(RSTN), .INSTRUCTION(INSTRUCTION), .PC(PC),
        .DECODE_EN(DECODE_EN), .EXEC_EN(EXEC_EN), .RS1(RS1), .RS2(RS2),
        .RS1_VAL(RS1_VAL), .RS2_VAL(RS2_VAL), .JUMP_DEST(JUMP_DEST),
        .EXEC_RD(EXEC_RD), .MEMORY_OUT(MEMORY_OUT), .RD(RD),
        .WRITE_ENABLE(WRITE_ENABLE), .WRITE_DATA(WRITE_DATA)
    );

    always #5 CLK = ~CLK;

    localparam int OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam int OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011;
    localparam int OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_R = 7'b0110011;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] m, a, f, d, o;
        m = imm; a = rs1; f = f3; d = rd; o = op;
        return {m[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[11:5], b[4:0], a[4:0], f[2:0], m[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[12], m[10:5], b[4:0], a[4:0], f[2:0], m[4:1], m[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] m, d;
        m = imm; d = rd;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input int imm, input int rd, input int op);
        logic [31:0] m, d, o;
        m = imm; d = rd; o = op;
        return {m[31:12], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] s, b, a, f, d;
        s = f7; b = rs2; a = rs1; f = f3; d = rd;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
    endfunction

    // One decode/execute/write pass; returns with the write cycle in progress.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] v1,
                        input logic [31:0] v2, input logic rst_exec, output logic [31:0] jd);
        @(negedge CLK);
        INSTRUCTION = ins; PC = pc; DECODE_EN = 1'b1;
        @(negedge CLK);
        DECODE_EN = 1'b0; RS1_VAL = v1; RS2_VAL = v2; EXEC_EN = 1'b1; RSTN = rst_exec;
        #1 jd = JUMP_DEST;
        @(negedge CLK);
        EXEC_EN = 1'b0; RSTN = 1'b0;
        #1;
    endtask

    logic [31:0] prog [36];
    logic [31:0] regs [32];
    logic [31:0] pc;

    task automatic run_prog(input int limit, input int rst_at, output int n_exec);
        logic [31:0] nxt;
        logic        stop;
        stop = 1'b0;
        pc = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[2] = 32'd500;
        n_exec = 0;
        while (pc != 35 && n_exec < limit && !stop) begin
            @(negedge CLK);
            INSTRUCTION = prog[pc[5:0]]; PC = pc; DECODE_EN = 1'b1;
            @(negedge CLK);
            DECODE_EN = 1'b0; RS1_VAL = regs[RS1]; RS2_VAL = regs[RS2]; EXEC_EN = 1'b1;
            if (n_exec == rst_at) RSTN = 1'b1;
            #1 nxt = JUMP_DEST;
            @(negedge CLK);
            EXEC_EN = 1'b0;
            #1;
            if (RSTN) begin
                RSTN = 1'b0;
                check("midrun_rst_we", {31'b0, WRITE_ENABLE}, 32'd0);
                check("midrun_rst_exec_rd", EXEC_RD, 32'd0);
                check("midrun_rst_mem_out", MEMORY_OUT, 32'd0);
                check("midrun_rst_rd", {27'b0, RD}, 32'd0);
                stop = 1'b1;
            end else begin
                if (WRITE_ENABLE) regs[RD] = WRITE_DATA;
                regs[0] = 32'd0;
                pc = nxt;
                n_exec++;
                if (pc > 35) begin
                    check("pc_in_program", pc, 32'd35);
                    stop = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] jd;
        int n;

        prog[0]  = enc_j(116, 1);
        prog[1]  = enc_i(-32, 2, 0, 2, OP_IMM);
        prog[2]  = enc_s(28, 1, 2, 2);
        prog[3]  = enc_s(24, 8, 2, 2);
        prog[4]  = enc_s(20, 9, 2, 2);
        prog[5]  = enc_i(32, 2, 0, 8, OP_IMM);
        prog[6]  = enc_s(-20, 10, 8, 2);
        prog[7]  = enc_i(-20, 8, 2, 14, OP_LD);
        prog[8]  = enc_i(1, 0, 0, 15, OP_IMM);
        prog[9]  = enc_b(12, 14, 15, 4);
        prog[10] = enc_i(1, 0, 0, 15, OP_IMM);
        prog[11] = enc_j(48, 0);
        prog[12] = enc_i(-20, 8, 2, 15, OP_LD);
        prog[13] = enc_i(-1, 15, 0, 15, OP_IMM);
        prog[14] = enc_i(0, 15, 0, 10, OP_IMM);
        prog[15] = enc_j(-56, 1);
        prog[16] = enc_i(0, 10, 0, 9, OP_IMM);
        prog[17] = enc_i(-20, 8, 2, 15, OP_LD);
        prog[18] = enc_i(-2, 15, 0, 15, OP_IMM);
        prog[19] = enc_i(0, 15, 0, 10, OP_IMM);
        prog[20] = enc_j(-76, 1);
        prog[21] = enc_i(0, 10, 0, 15, OP_IMM);
        prog[22] = enc_r(0, 15, 9, 0, 15);
        prog[23] = enc_i(0, 15, 0, 10, OP_IMM);
        prog[24] = enc_i(28, 2, 2, 1, OP_LD);
        prog[25] = enc_i(24, 2, 2, 8, OP_LD);
        prog[26] = enc_i(20, 2, 2, 9, OP_LD);
        prog[27] = enc_i(32, 2, 0, 2, OP_IMM);
        prog[28] = enc_i(0, 1, 0, 0, OP_JALR);
        prog[29] = enc_i(-16, 2, 0, 2, OP_IMM);
        prog[30] = enc_s(12, 1, 2, 2);
        prog[31] = enc_i(12, 0, 0, 10, OP_IMM);
        prog[32] = enc_j(-124, 1);
        prog[33] = enc_i(12, 2, 2, 1, OP_LD);
        prog[34] = enc_i(16, 2, 0, 2, OP_IMM);
        prog[35] = enc_i(0, 1, 0, 0, OP_JALR);

        RSTN = 1'b1; DECODE_EN = 1'b0; EXEC_EN = 1'b0;
        INSTRUCTION = 32'd0; PC = 32'd7; RS1_VAL = 32'd0; RS2_VAL = 32'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b0;
        #1;
        check("reset_exec_rd", EXEC_RD, 32'd0);
        check("reset_mem_out", MEMORY_OUT, 32'd0);
        check("reset_rd", {27'b0, RD}, 32'd0);
        check("reset_we", {31'b0, WRITE_ENABLE}, 32'd0);
        check("reset_jump_dest", JUMP_DEST, 32'd8);

        // addi x15,x0,1
        step(32'h00100793, 32'd8, 32'd0, 32'd0, 1'b0, jd);
        check("addi_rs1", {27'b0, RS1}, 32'd0);
        check("addi_jd", jd, 32'd9);
        check("addi_we", {31'b0, WRITE_ENABLE}, 32'd1);
        check("addi_rd", {27'b0, RD}, 32'd15);
        check("addi_wd", WRITE_DATA, 32'd1);

        // sw x10,-20(x8) then lw x14,-20(x8)
        step(enc_s(-20, 10, 8, 2), 32'd3, 32'd500, 32'd12, 1'b0, jd);
        check("sw_rs1", {27'b0, RS1}, 32'd8);
        check("sw_rs2", {27'b0, RS2}, 32'd10);
        check("sw_we", {31'b0, WRITE_ENABLE}, 32'd0);
        check("sw_jd", jd, 32'd4);
        step(enc_i(-20, 8, 2, 14, OP_LD), 32'd4, 32'd500, 32'd0, 1'b0, jd);
        check("lw_wd", WRITE_DATA, 32'd12);
        check("lw_we", {31'b0, WRITE_ENABLE}, 32'd1);
        check("lw_rd", {27'b0, RD}, 32'd14);

        // jal ra,+0x74 at PC 0; ret with ra=140
        step(32'h074000EF, 32'd0, 32'd0, 32'd0, 1'b0, jd);
        check("jal_jd", jd, 32'd29);
        check("jal_wd", WRITE_DATA, 32'd4);
        check("jal_rd", {27'b0, RD}, 32'd1);
        step(32'h00008067, 32'd30, 32'd140, 32'd0, 1'b0, jd);
        check("ret_jd", jd, 32'd35);
        check("ret_we", {31'b0, WRITE_ENABLE}, 32'd0);

        // jalr x1,6(x5) at PC 3: odd target bit dropped, link is byte PC+4
        step(enc_i(6, 5, 0, 1, OP_JALR), 32'd3, 32'd100, 32'd0, 1'b0, jd);
        check("jalr_jd", jd, 32'd26);
        check("jalr_wd", WRITE_DATA, 32'd16);

        // branches
        step(enc_b(12, 14, 15, 4), 32'd9, 32'd1, 32'd2, 1'b0, jd);
        check("blt_taken", jd, 32'd12);
        step(enc_b(12, 14, 15, 4), 32'd9, 32'd1, 32'd1, 1'b0, jd);
        check("blt_equal_not_taken", jd, 32'd10);
        step(enc_b(12, 14, 15, 4), 32'd9, 32'hFFFFFFFF, 32'd2, 1'b0, jd);
        check("blt_negative_taken", jd, 32'd12);
        step(enc_b(12, 14, 15, 6), 32'd9, 32'hFFFFFFFF, 32'd2, 1'b0, jd);
        check("bltu_not_taken", jd, 32'd10);
        step(enc_b(-8, 2, 1, 7), 32'd10, 32'hFFFFFFFF, 32'd1, 1'b0, jd);
        check("bgeu_back_taken", jd, 32'd8);
        check("branch_we", {31'b0, WRITE_ENABLE}, 32'd0);

        // ALU
        step(enc_r(32, 3, 2, 0, 1), 32'd0, 32'd5, 32'd7, 1'b0, jd);
        check("sub", WRITE_DATA, 32'hFFFFFFFE);
        step(enc_r(32, 3, 2, 5, 1), 32'd0, 32'h80000000, 32'd36, 1'b0, jd);
        check("sra_shamt5", WRITE_DATA, 32'hF8000000);
        step(enc_r(0, 3, 2, 5, 1), 32'd0, 32'h80000000, 32'd36, 1'b0, jd);
        check("srl", WRITE_DATA, 32'h08000000);
        step(enc_r(0, 3, 2, 2, 1), 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, jd);
        check("slt", WRITE_DATA, 32'd0);
        step(enc_r(0, 3, 2, 3, 1), 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, jd);
        check("sltu", WRITE_DATA, 32'd1);
        step(enc_i(32'h404, 2, 5, 1, OP_IMM), 32'd0, 32'h80000000, 32'd0, 1'b0, jd);
        check("srai", WRITE_DATA, 32'hF8000000);
        step(enc_i(-1, 2, 3, 1, OP_IMM), 32'd0, 32'd5, 32'd0, 1'b0, jd);
        check("sltiu", WRITE_DATA, 32'd1);
        step(enc_u(32'h12345000, 3, OP_LUI), 32'd6, 32'd0, 32'd0, 1'b0, jd);
        check("lui", WRITE_DATA, 32'h12345000);
        check("lui_jd", jd, 32'd7);
        step(enc_u(32'h00001000, 3, OP_AUIPC), 32'd4, 32'd0, 32'd0, 1'b0, jd);
        check("auipc", WRITE_DATA, 32'h00001010);

        // byte/half access into the word at byte 100
        step(enc_s(100, 5, 0, 2), 32'd0, 32'd0, 32'h11223344, 1'b0, jd);
        step(enc_s(101, 6, 0, 0), 32'd0, 32'd0, 32'h123456AB, 1'b0, jd);
        step(enc_i(101, 0, 0, 7, OP_LD), 32'd0, 32'd0, 32'd0, 1'b0, jd);
        check("lb", WRITE_DATA, 32'hFFFFFFAB);
        step(enc_i(101, 0, 4, 7, OP_LD), 32'd0, 32'd0, 32'd0, 1'b0, jd);
        check("lbu", MEMORY_OUT, 32'h000000AB);
        step(enc_i(100, 0, 2, 7, OP_LD), 32'd0, 32'd0, 32'd0, 1'b0, jd);
        check("lw_after_sb", WRITE_DATA, 32'h1122AB44);
        step(enc_i(100, 0, 1, 7, OP_LD), 32'd0, 32'd0, 32'd0, 1'b0, jd);
        check("lh", WRITE_DATA, 32'hFFFFAB44);
        step(enc_i(102, 0, 5, 7, OP_LD), 32'd0, 32'd0, 32'd0, 1'b0, jd);
        check("lhu_upper", WRITE_DATA, 32'h00001122);
        step(enc_i(102, 9, 2, 7, OP_LD), 32'd0, 32'd4096, 32'd0, 1'b0, jd);
        check("lw_wrap_misaligned", WRITE_DATA, 32'h1122AB44);
        step(enc_s(2, 6, 9, 1), 32'd0, 32'd4196, 32'h0000BEEF, 1'b0, jd);
        step(enc_i(100, 0, 2, 7, OP_LD), 32'd0, 32'd0, 32'd0, 1'b0, jd);
        check("sh_upper_wrap", WRITE_DATA, 32'hBEEFAB44);

        // NOP and x0 destination
        step(32'h0000000B, 32'd20, 32'd0, 32'd0, 1'b0, jd);
        check("nop_jd", jd, 32'd21);
        check("nop_we", {31'b0, WRITE_ENABLE}, 32'd0);
        step(enc_i(5, 0, 0, 0, OP_IMM), 32'd0, 32'd0, 32'd0, 1'b0, jd);
        check("rd_x0_we", {31'b0, WRITE_ENABLE}, 32'd0);

        // store suppressed by reset in the execute cycle
        step(enc_s(200, 5, 0, 2), 32'd0, 32'd0, 32'h00000055, 1'b0, jd);
        step(enc_i(200, 0, 2, 7, OP_LD), 32'd0, 32'd0, 32'd0, 1'b0, jd);
        check("pre_rst_load", MEMORY_OUT, 32'h00000055);
        step(enc_s(200, 5, 0, 2), 32'd0, 32'd0, 32'h00000099, 1'b1, jd);
        check("rst_exec_rd", EXEC_RD, 32'd0);
        check("rst_mem_out", MEMORY_OUT, 32'd0);
        check("rst_rd", {27'b0, RD}, 32'd0);
        step(enc_i(200, 0, 2, 7, OP_LD), 32'd0, 32'd0, 32'd0, 1'b0, jd);
        check("store_suppressed", WRITE_DATA, 32'h00000055);

        // reset beats DECODE_EN on the same edge
        @(negedge CLK);
        INSTRUCTION = 32'h00100793; PC = 32'd8; DECODE_EN = 1'b1; RSTN = 1'b1;
        @(negedge CLK);
        DECODE_EN = 1'b0; RSTN = 1'b0; EXEC_EN = 1'b1;
        #1 check("rst_decode_jd", JUMP_DEST, 32'd9);
        @(negedge CLK);
        EXEC_EN = 1'b0;
        #1 check("rst_decode_we", {31'b0, WRITE_ENABLE}, 32'd0);

        // fib program: reset partway, then a full run
        run_prog(60, 40, n);
        run_prog(20000, -1, n);
        check("fib_pc", pc, 32'd35);
        check("fib_x10", regs[10], 32'd233);
        check("fib_sp", regs[2], 32'd500);
        $display("fib run: %0d instructions", n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv32i_decode_exec_wb.md
Name: rv32i_decode_exec_wb

Overview:
- Decode, execute and write-back datapath of the team's multicycle RV32I core (fetch → decode → execute → write, one state per clock).
- The CPU shell owns the PC, the instruction register and the 32×32 register file.
  - It supplies the fetched instruction, the PC, and the register values read with this block's RS1/RS2 indices.
  - It consumes the next PC and the register write-back request.
- The block contains the data memory.

Parameters:
DMEM_WORDS, 1024, data memory depth in 32-bit words; byte address bits [log2(DMEM_WORDS)+1:2] select the word.

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RSTN  input  1  reset; synchronous, active-high
INSTRUCTION  input  32  current instruction, stable from decode through write
PC  input  32  word-indexed PC of INSTRUCTION; byte PC = PC<<2
DECODE_EN  input  1  capture decoded control info this edge (decode state)
EXEC_EN  input  1  perform execute this edge (execute state)
RS1  output  5  INSTRUCTION[19:15], combinational
RS2  output  5  INSTRUCTION[24:20], combinational
RS1_VAL  input  32  register value for RS1, latched by the shell at the decode edge
RS2_VAL  input  32  register value for RS2, latched by the shell at the decode edge
JUMP_DEST  output  32  next word-indexed PC, combinational
EXEC_RD  output  32  registered ALU/link result
MEMORY_OUT  output  32  registered load data, extended
RD  output  5  registered destination register index
WRITE_ENABLE  output  1  combinational register-write request
WRITE_DATA  output  32  combinational write data

Behaviour:
- Decoded control state:
  - Captured on a rising edge with DECODE_EN=1.
  - Fields: opcode class, funct3, funct7 bit 5, rd, sign-extended immediate (I/S/B/U/J formats), byte PC.
  - Held otherwise.
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP ALU ops (SLT/SLTU signed/unsigned, SRA arithmetic, shift amount = low 5 bits).
- Any other opcode executes as a NOP: no write, no store, JUMP_DEST = PC+1.
- JUMP_DEST (combinational from control state, RS1_VAL, RS2_VAL):
  - Default: PC+1.
  - JAL: (bytePC + immJ)>>2.
  - Taken branch: (bytePC + immB)>>2.
  - JALR: ((RS1_VAL + immI) & ~1)>>2.
  - Valid in the execute cycle.
- Link value for JAL/JALR = bytePC + 4, i.e. a byte address.
- AUIPC result = bytePC + immU.
- On a rising edge with EXEC_EN=1:
  - EXEC_RD ← ALU/link result.
  - For loads, MEMORY_OUT ← the addressed byte/half/word, sign- or zero-extended per funct3.
  - For stores, the addressed byte/half/word is written; other bytes of the word are unchanged; little-endian.
  - Effective address = RS1_VAL + imm.
  - Misaligned or out-of-range addresses: low address bits are ignored for word select; the index wraps modulo DMEM_WORDS.
- Load data in MEMORY_OUT is available on the edge following execute.
- Write-back (combinational):
  - WRITE_ENABLE = 1 for LUI, AUIPC, JAL, JALR, loads, OP-IMM, OP when rd≠0; otherwise 0.
  - WRITE_DATA = MEMORY_OUT for loads, else EXEC_RD.
- Reset (RSTN=1 on a rising edge):
  - Control state becomes NOP, so WRITE_ENABLE=0.
  - EXEC_RD=0, MEMORY_OUT=0, RD=0.
  - Memory contents are preserved; memory is zero at power-up.
  - Reset takes priority over DECODE_EN/EXEC_EN asserted in the same cycle.
- EXEC_EN with a store and reset in the same cycle: the store is suppressed.

Test Plan:
- addi x15,x0,1 (0x00100793), PC=8 → RS1=0; after execute WRITE_ENABLE=1, RD=15, WRITE_DATA=1, JUMP_DEST=9.
- sw x10,-20(x8) with RS1_VAL=500, RS2_VAL=12, then lw x14,-20(x8) → WRITE_DATA=12; store alone → WRITE_ENABLE=0.
- jal ra,+0x74 (0x074000EF) at PC=0 → JUMP_DEST=29, WRITE_DATA=4, RD=1; ret (0x00008067) with RS1_VAL=140 → JUMP_DEST=35, WRITE_ENABLE=0.
- blt x15,x14,+12 at PC=9: RS1_VAL=1, RS2_VAL=2 → JUMP_DEST=12; with RS2_VAL=1 → JUMP_DEST=10; with RS1_VAL=0xFFFFFFFF and bltu → not taken.
- sb 0xAB at byte addr 101, then lb and lbu → 0xFFFFFFAB and 0x000000AB; rest of the word unchanged.
- Full 36-instruction recursive fib(12) program in a shell with sp=500 → x10=233 when PC reaches 35; reset mid-run clears outputs with no spurious write.
